// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI byte parser and its output holding register.
package midi_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned CHAN_W = 4;
    localparam int unsigned DATA_W = 7;

    typedef enum logic [TYPE_W-1:0] {
        MSG_NOTE_OFF = 3'd0,
        MSG_NOTE_ON  = 3'd1,
        MSG_POLY_AT  = 3'd2,
        MSG_CC       = 3'd3,
        MSG_PROG     = 3'd4,
        MSG_CHAN_AT  = 3'd5,
        MSG_PITCH    = 3'd6
    } msg_type_e;

    localparam logic [3:0] NIB_NOTE_OFF = 4'h8;
    localparam logic [3:0] NIB_NOTE_ON  = 4'h9;
    localparam logic [3:0] NIB_POLY_AT  = 4'hA;
    localparam logic [3:0] NIB_CC       = 4'hB;
    localparam logic [3:0] NIB_PROG     = 4'hC;
    localparam logic [3:0] NIB_CHAN_AT  = 4'hD;
    localparam logic [3:0] NIB_PITCH    = 4'hE;

    localparam logic [BYTE_W-1:0] SYS_FIRST = 8'hF0;
    localparam logic [BYTE_W-1:0] SYS_EOX   = 8'hF7;
    localparam logic [BYTE_W-1:0] RT_FIRST  = 8'hF8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_D1   = 2'd1,
        S_D2   = 2'd2,
        S_SKIP = 2'd3
    } state_e;

    typedef struct packed {
        msg_type_e         msg_type;
        logic [CHAN_W-1:0] chan;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
    } midi_msg_t;

    // Voice status nibbles 0x8..0xE map linearly onto message types 0..6.
    function automatic msg_type_e nib_to_type(input logic [3:0] nib);
        return msg_type_e'(TYPE_W'(nib - NIB_NOTE_OFF));
    endfunction

endpackage

// File: rtl/midi_out_reg.sv
// One-entry valid/ready holding register; a load that finds it full and not draining is dropped with an overrun pulse.
module midi_out_reg
    import midi_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_load,
    input  midi_msg_t i_msg,
    input  logic      i_rdy,
    output midi_msg_t o_msg,
    output logic      o_vld,
    output logic      o_overrun
);

    midi_msg_t msg_q, msg_d;
    logic      vld_q, vld_d;
    logic      ovr_q, ovr_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            msg_q <= '0;
            vld_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            msg_q <= msg_d;
            vld_q <= vld_d;
            ovr_q <= ovr_d;
        end
    end

    // A same-cycle handshake frees the slot, so completion and consumption can overlap.
    always_comb begin
        msg_d = msg_q;
        vld_d = vld_q;
        ovr_d = 1'b0;
        if (i_load) begin
            if (!vld_q || i_rdy) begin
                msg_d = i_msg;
                vld_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (vld_q && i_rdy) begin
            vld_d = 1'b0;
        end
    end

    assign o_msg     = msg_q;
    assign o_vld     = vld_q;
    assign o_overrun = ovr_q;

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser: tracks (running) status, assembles channel-voice messages and filters by channel.
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter bit         OMNI    = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] i_byte,
    input  logic              i_byte_vld,
    output logic [TYPE_W-1:0] o_msg_type,
    output logic [CHAN_W-1:0] o_chan,
    output logic [DATA_W-1:0] o_d1,
    output logic [DATA_W-1:0] o_d2,
    output logic              o_msg_vld,
    input  logic              i_msg_rdy,
    output logic              o_overrun
);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] status_q, status_d;
    logic [DATA_W-1:0] d1_q, d1_d;

    logic      is_data, is_voice, is_sys, is_eox, one_byte;
    logic      done_c, accept_c;
    midi_msg_t msg_c;
    midi_msg_t out_msg;

    // Realtime bytes (0xF8..0xFF) fall in no class and therefore touch nothing.
    assign is_data  = i_byte_vld && !i_byte[BYTE_W-1];
    assign is_voice = i_byte_vld && i_byte[BYTE_W-1] && (i_byte < SYS_FIRST);
    assign is_sys   = i_byte_vld && (i_byte >= SYS_FIRST) && (i_byte < RT_FIRST);
    assign is_eox   = (i_byte == SYS_EOX);
    assign one_byte = (status_q[7:4] == NIB_PROG) || (status_q[7:4] == NIB_CHAN_AT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            status_q <= '0;
            d1_q     <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            d1_q     <= d1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (is_voice) begin
            state_d = S_D1;
        end else if (is_sys) begin
            state_d = is_eox ? S_IDLE : S_SKIP;
        end else if (is_data) begin
            case (state_q)
                S_D1:    state_d = one_byte ? S_D1 : S_D2;
                S_D2:    state_d = S_D1;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        status_d = status_q;
        d1_d     = d1_q;
        msg_c    = '0;
        if (is_voice) begin
            status_d = i_byte;
        end else if (is_sys) begin
            status_d = '0;
        end
        if (is_data && (state_q == S_D1)) begin
            d1_d = i_byte[DATA_W-1:0];
        end

        msg_c.chan     = status_q[3:0];
        msg_c.msg_type = nib_to_type(status_q[7:4]);
        if ((state_q == S_D1) && one_byte) begin
            msg_c.d1 = i_byte[DATA_W-1:0];
            msg_c.d2 = '0;
        end else begin
            msg_c.d1 = d1_q;
            msg_c.d2 = i_byte[DATA_W-1:0];
        end
        // Note-on with zero velocity is the conventional note-off.
        if ((msg_c.msg_type == MSG_NOTE_ON) && (msg_c.d2 == '0)) begin
            msg_c.msg_type = MSG_NOTE_OFF;
        end

        done_c   = is_data && (((state_q == S_D1) && one_byte) || (state_q == S_D2));
        accept_c = done_c && (OMNI || (status_q[3:0] == CHANNEL));
    end

    midi_out_reg u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (accept_c),
        .i_msg     (msg_c),
        .i_rdy     (i_msg_rdy),
        .o_msg     (out_msg),
        .o_vld     (o_msg_vld),
        .o_overrun (o_overrun)
    );

    assign o_msg_type = out_msg.msg_type;
    assign o_chan     = out_msg.chan;
    assign o_d1       = out_msg.d1;
    assign o_d2       = out_msg.d2;

endmodule

// File: doc/midi_msg_parser.md
Name: midi_msg_parser

Overview:
- Byte-level MIDI protocol controller between the UART receiver and the synth voice logic.
- Consumes one received byte per strobe and tracks status and running status.
- Assembles complete channel-voice messages and presents them on a valid/ready interface with a single holding register.
- Filters by channel, drops system-exclusive and system-common traffic, and leaves realtime bytes transparent.

Parameters:
- CHANNEL, 0, 4-bit MIDI channel accepted when OMNI=0.
- OMNI, 0, 1 = accept all channels; 0 = accept CHANNEL only.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- i_byte  in  8  received byte; valid only when i_byte_vld=1
- i_byte_vld  in  1  one-cycle strobe per received byte (UART ready flag)
- o_msg_type  out  3  0 NOTE_OFF, 1 NOTE_ON, 2 POLY_AT, 3 CC, 4 PROG, 5 CHAN_AT, 6 PITCH
- o_chan  out  4  channel of the message
- o_d1  out  7  first data byte (note, controller, program, pressure, pitch LSB)
- o_d2  out  7  second data byte (velocity, value, pitch MSB); 0 for 1-data-byte messages
- o_msg_vld  out  1  holding register contains a message
- i_msg_rdy  in  1  consumer accepts; transfer occurs when o_msg_vld & i_msg_rdy
- o_overrun  out  1  one-cycle pulse when a completed message is dropped

Behaviour:
- Reset: all outputs 0, state S_IDLE, running status cleared, holding register empty.
- Reset mid-message: partial bytes are discarded.
- Byte classes:
  - Data byte: bit7=0.
  - Voice status: 0x80–0xEF.
  - System common / sysex: 0xF0–0xF7.
  - Realtime: 0xF8–0xFF.
- Realtime bytes are ignored in every state. They cause no state change and do not alter running status.
- States:
  - S_IDLE: no valid running status.
  - S_D1: awaiting first data byte.
  - S_D2: awaiting second data byte.
  - S_SKIP: discarding data bytes.
- Voice status from any state:
  - Store it as running status.
  - Go to S_D1.
  - Any partially assembled message is abandoned without an overrun pulse.
- 0xF0–0xF6: clear running status and go to S_SKIP.
- 0xF7: clear running status and go to S_IDLE.
- Data byte handling by state:
  - S_IDLE or S_SKIP: discarded.
  - S_D1: latch d1. For 0xC/0xD status, complete the message with d2=0 and stay in S_D1. Otherwise go to S_D2.
  - S_D2: latch d2, complete the message, return to S_D1 (running status).
- Type mapping: status nibble 0x8–0xE maps to types 0–6.
- NOTE_ON with d2=0 is reported as NOTE_OFF with d2=0.
- Channel filter: a completed message whose channel fails the filter is silently discarded. Parsing and running status proceed normally.
- Output load:
  - A completed, accepted message loads the holding register on the cycle after the final byte strobe. o_msg_vld rises on that same edge, so latency is 1 clk from i_byte_vld.
  - The load is permitted if the register is empty, or if it is being consumed in the current cycle (o_msg_vld & i_msg_rdy). Back-to-back completion and consumption must lose no message.
  - Otherwise the new message is dropped, the held message is unchanged, and o_overrun pulses for 1 clk.
- o_msg_vld clears after a handshake unless a new load occurs on the same cycle.
- Output fields are stable while o_msg_vld=1 and i_msg_rdy=0.
- i_byte is ignored when i_byte_vld=0. Consecutive strobes on adjacent cycles must be handled.

Decomposition:
- Package midi_pkg:
  - message-type encodings;
  - status nibble constants (0x8–0xE);
  - byte class boundaries (0xF0, 0xF7, 0xF8);
  - state encodings.
- Sub-module midi_out_reg: one-entry valid/ready holding register with overrun pulse generation. The parser FSM stays in midi_msg_parser.

Test Plan:
1. Note-on: strobes 0x90,0x3C,0x64 (OMNI=1) → one cycle after the third strobe: type=1, chan=0, d1=0x3C, d2=0x64, o_msg_vld=1. With i_msg_rdy=1, o_msg_vld clears the next cycle.
2. Running status and realtime: 0x92,0x40,0xF8,0x50,0x41,0x00 → two messages: (NOTE_ON, ch2, 0x40, 0x50) and (NOTE_OFF, ch2, 0x41, 0x00). No effect from 0xF8.
3. One-data-byte messages: 0xC5,0x07,0x09 → (PROG, ch5, 0x07, 0) then (PROG, ch5, 0x09, 0).
4. Filter and sysex: CHANNEL=3, OMNI=0. Send 0x91,0x3C,0x40 → no output. Then 0xF0,0x11,0x22,0xF7,0x10 → no output. Then 0x93,0x3C,0x40 → one NOTE_ON, ch3.
5. Backpressure: i_msg_rdy=0, two complete note-ons → first held unchanged, second dropped, o_overrun pulses exactly 1 clk. Raise i_msg_rdy → first message transferred, o_msg_vld=0.
6. Reset mid-message: 0x90,0x3C, assert rst_n=0 for 1 clk, then 0x64 → no message, all outputs 0.
